nerv_dbg_trig: RTL and testbench
================================

NERV_DBG_TRIG -- requirements
Module: nerv_dbg_trig

Interface
REQ-001 SHALL have parameter XLEN, default 32, address/PC width.
REQ-002 SHALL have parameter BNUM, default 4, number of trigger slots (1..8).
REQ-003 SHALL have port clk input 1, single clock; all state on rising edge.
REQ-004 SHALL have port rst input 1, reset: synchronous, active-low.
REQ-005 SHALL have ports ret_vld input 1 / ret_pc input XLEN, CPU instruction retire strobe and PC.
REQ-006 SHALL have ports mem_vld input 1 / mem_wr input 1 / mem_adr input XLEN, CPU data access strobe, write flag, address.
REQ-007 SHALL have ports cfg_we input 1 / cfg_idx input $clog2(BNUM) / cfg_ena input 1 / cfg_typ input 2 / cfg_adr input XLEN, stub trigger-slot write (typ: 0 exec, 1 write, 2 read, 3 access).
REQ-008 SHALL have ports cmd_vld input 1 / cmd_op input 2 / cmd_rdy output 1, stub command handshake (op: 0 continue, 1 step, 2 halt).
REQ-009 SHALL have port cpu_stall output 1, stall request to CPU.
REQ-010 SHALL have ports hlt output 1 / hlt_sig output 8 / hlt_idx output $clog2(BNUM) / hlt_adr output XLEN, halted flag, GDB signal number, hitting slot, hitting PC/address.

Function
REQ-011 SHALL implement FSM states HALTED, RUN, STEP; cpu_stall=1 and hlt=1 exactly in HALTED.
REQ-012 SHALL accept a command when cmd_vld and cmd_rdy are both high; cmd_rdy is 1 in every state.
REQ-013 SHALL in HALTED: continue -> RUN, step -> STEP, halt -> ignored (stay HALTED).
REQ-014 SHALL in RUN/STEP: halt -> HALTED next cycle, hlt_sig=2 (SIGINT), hlt_adr=last retired PC; continue/step ignored.
REQ-015 SHALL in STEP: first ret_vld -> HALTED next cycle, hlt_sig=5 (SIGTRAP), hlt_adr=ret_pc.
REQ-016 SHALL in RUN: enabled exec slot with ret_vld and ret_pc==cfg_adr -> HALTED next cycle, hlt_sig=5, hlt_idx=slot, hlt_adr=ret_pc.
REQ-017 SHALL not evaluate exec slots on the first retirement after leaving HALTED, so continuing from a breakpoint PC makes progress.
REQ-018 SHALL on multiple simultaneous slot hits report the lowest index.
REQ-019 SHALL give trigger hit priority over a halt command in the same cycle (hlt_sig=5).
REQ-020 SHALL apply cfg_we in any state; a slot written in cycle N participates in matching from cycle N+1.
REQ-021 SHALL hold hlt_sig/hlt_idx/hlt_adr stable while HALTED; updated only on entry to HALTED.
REQ-022 SHALL latch the last retired PC on every ret_vld regardless of state.

Reset
REQ-023 SHALL on rst low: state HALTED, cpu_stall=1, hlt=1, hlt_sig=5, hlt_idx=0, hlt_adr=0, last PC=0, all slots disabled (ena=0, typ=0, adr=0).
REQ-024 SHALL let reset override any in-flight command, hit or configuration write in the same cycle.

Configuration
REQ-025 SHALL compile data watchpoints only when NERV_DBG_WATCH_EN is defined: with mem_vld and slot typ 1 (mem_wr=1), 2 (mem_wr=0) or 3 (either) and mem_adr==cfg_adr, RUN -> HALTED, hlt_sig=5, hlt_adr=mem_adr; exec hits win over watch hits in the same cycle.
REQ-026 SHALL without NERV_DBG_WATCH_EN ignore mem_* inputs and treat typ 1..3 slots as never matching.

Verification
REQ-027 SHALL cover: reset, then continue cmd -> cpu_stall=0 next cycle; halt cmd -> hlt=1, hlt_sig=2, hlt_adr=last PC.
REQ-028 SHALL cover: slot0 exec 0x0000_0010 enabled, continue, retire 0x0C,0x10 -> HALTED after 0x10, hlt_idx=0, hlt_adr=0x10; continue, retire 0x10 -> stays RUN.
REQ-029 SHALL cover: step from HALTED, retire 0x20 -> HALTED, hlt_sig=5, hlt_adr=0x20; step with no retire for 10 cycles -> stays STEP.
REQ-030 SHALL cover: slots 1 and 3 both exec 0x40, retire 0x40 together with halt cmd -> hlt_idx=1, hlt_sig=5.
REQ-031 SHALL cover (NERV_DBG_WATCH_EN): slot2 typ 1 adr 0x8000_0000, read access there -> no halt; write there -> HALTED, hlt_adr=0x8000_0000; without macro -> no halt.
REQ-032 SHALL cover: rst low during RUN with slots enabled -> HALTED, all slots disabled, outputs at REQ-023 values.

Source files
------------

// File: rtl/nerv_dbg_trig.sv
// nerv_dbg_trig: debug halt/run/step controller with PC breakpoint slots.
// Optional data watchpoints are compiled in when NERV_DBG_WATCH_EN is defined.
module nerv_dbg_trig #(
  parameter int unsigned XLEN = 32,
  parameter int unsigned BNUM = 4,
  localparam int unsigned IW  = (BNUM > 1) ? $clog2(BNUM) : 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            ret_vld,
  input  logic [XLEN-1:0] ret_pc,
  input  logic            mem_vld,
  input  logic            mem_wr,
  input  logic [XLEN-1:0] mem_adr,
  input  logic            cfg_we,
  input  logic [IW-1:0]   cfg_idx,
  input  logic            cfg_ena,
  input  logic [1:0]      cfg_typ,
  input  logic [XLEN-1:0] cfg_adr,
  input  logic            cmd_vld,
  input  logic [1:0]      cmd_op,
  output logic            cmd_rdy,
  output logic            cpu_stall,
  output logic            hlt,
  output logic [7:0]      hlt_sig,
  output logic [IW-1:0]   hlt_idx,
  output logic [XLEN-1:0] hlt_adr
);

  localparam logic [1:0] OP_CONT = 2'd0;
  localparam logic [1:0] OP_STEP = 2'd1;
  localparam logic [1:0] OP_HALT = 2'd2;
  localparam logic [7:0] SIGINT  = 8'd2;
  localparam logic [7:0] SIGTRAP = 8'd5;

  typedef enum logic [1:0] {
    S_HALTED = 2'd0,
    S_RUN    = 2'd1,
    S_STEP   = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic              skip_q, skip_d;
  logic [7:0]        sig_q, sig_d;
  logic [IW-1:0]     idx_q, idx_d;
  logic [XLEN-1:0]   hadr_q, hadr_d;
  logic [XLEN-1:0]   last_pc_q;
  logic              ena_q [BNUM];
  logic [1:0]        typ_q [BNUM];
  logic [XLEN-1:0]   adr_q [BNUM];

  logic              exec_hit, watch_hit;
  logic [IW-1:0]     exec_idx, watch_idx;
  logic              halt_cmd;

  assign halt_cmd  = cmd_vld && (cmd_op == OP_HALT);
  assign cmd_rdy   = 1'b1;
  assign cpu_stall = (state_q == S_HALTED);
  assign hlt       = (state_q == S_HALTED);
  assign hlt_sig   = sig_q;
  assign hlt_idx   = idx_q;
  assign hlt_adr   = hadr_q;

  // Exec slot match on the retiring PC; descending scan leaves the lowest index.
  always_comb begin
    exec_hit = 1'b0;
    exec_idx = '0;
    for (int i = int'(BNUM) - 1; i >= 0; i--) begin
      if (ena_q[i] && (typ_q[i] == 2'd0) && (ret_pc == adr_q[i])) begin
        exec_hit = 1'b1;
        exec_idx = IW'(i);
      end
    end
  end

`ifdef NERV_DBG_WATCH_EN
  // Data watchpoint match on the current memory access.
  always_comb begin
    watch_hit = 1'b0;
    watch_idx = '0;
    for (int i = int'(BNUM) - 1; i >= 0; i--) begin
      if (mem_vld && ena_q[i] && (mem_adr == adr_q[i]) &&
          (((typ_q[i] == 2'd1) && mem_wr) ||
           ((typ_q[i] == 2'd2) && !mem_wr) ||
           (typ_q[i] == 2'd3))) begin
        watch_hit = 1'b1;
        watch_idx = IW'(i);
      end
    end
  end
`else
  logic unused_mem;
  assign unused_mem = ^{mem_vld, mem_wr, mem_adr};
  assign watch_hit  = 1'b0;
  assign watch_idx  = '0;
`endif

  // Next-state and halt-status logic; triggers outrank a halt command.
  always_comb begin
    state_d = state_q;
    skip_d  = skip_q;
    sig_d   = sig_q;
    idx_d   = idx_q;
    hadr_d  = hadr_q;
    case (state_q)
      S_HALTED: begin
        if (cmd_vld && (cmd_op == OP_CONT)) begin
          state_d = S_RUN;
          skip_d  = 1'b1;
        end else if (cmd_vld && (cmd_op == OP_STEP)) begin
          state_d = S_STEP;
          skip_d  = 1'b1;
        end
      end
      S_RUN: begin
        if (ret_vld) begin
          skip_d = 1'b0;
        end
        if (ret_vld && !skip_q && exec_hit) begin
          state_d = S_HALTED;
          sig_d   = SIGTRAP;
          idx_d   = exec_idx;
          hadr_d  = ret_pc;
        end else if (watch_hit) begin
          state_d = S_HALTED;
          sig_d   = SIGTRAP;
          idx_d   = watch_idx;
          hadr_d  = mem_adr;
        end else if (halt_cmd) begin
          state_d = S_HALTED;
          sig_d   = SIGINT;
          hadr_d  = last_pc_q;
        end
      end
      S_STEP: begin
        if (ret_vld) begin
          state_d = S_HALTED;
          sig_d   = SIGTRAP;
          hadr_d  = ret_pc;
        end else if (halt_cmd) begin
          state_d = S_HALTED;
          sig_d   = SIGINT;
          hadr_d  = last_pc_q;
        end
      end
      default: state_d = S_HALTED;
    endcase
  end

  // State and halt-status registers.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= S_HALTED;
      skip_q  <= 1'b0;
      sig_q   <= SIGTRAP;
      idx_q   <= '0;
      hadr_q  <= '0;
    end else begin
      state_q <= state_d;
      skip_q  <= skip_d;
      sig_q   <= sig_d;
      idx_q   <= idx_d;
      hadr_q  <= hadr_d;
    end
  end

  // Trigger slot table and last retired PC.
  always_ff @(posedge clk) begin
    if (!rst) begin
      last_pc_q <= '0;
      for (int unsigned i = 0; i < BNUM; i++) begin
        ena_q[i] <= 1'b0;
        typ_q[i] <= 2'd0;
        adr_q[i] <= '0;
      end
    end else begin
      if (ret_vld) begin
        last_pc_q <= ret_pc;
      end
      for (int unsigned i = 0; i < BNUM; i++) begin
        if (cfg_we && (cfg_idx == IW'(i))) begin
          ena_q[i] <= cfg_ena;
          typ_q[i] <= cfg_typ;
          adr_q[i] <= cfg_adr;
        end
      end
    end
  end

endmodule

// File: tb/tb_nerv_dbg_trig.sv
// Directed bench for nerv_dbg_trig with an expected-status scoreboard queue.
module tb_nerv_dbg_trig;

  localparam int unsigned XLEN = 32;
  localparam int unsigned BNUM = 4;
  localparam int unsigned IW   = 2;
`ifdef NERV_DBG_WATCH_EN
  localparam bit WATCH = 1'b1;
`else
  localparam bit WATCH = 1'b0;
`endif

  logic            clk = 1'b0;
  logic            rst;
  logic            ret_vld;
  logic [XLEN-1:0] ret_pc;
  logic            mem_vld;
  logic            mem_wr;
  logic [XLEN-1:0] mem_adr;
  logic            cfg_we;
  logic [IW-1:0]   cfg_idx;
  logic            cfg_ena;
  logic [1:0]      cfg_typ;
  logic [XLEN-1:0] cfg_adr;
  logic            cmd_vld;
  logic [1:0]      cmd_op;
  logic            cmd_rdy;
  logic            cpu_stall;
  logic            hlt;
  logic [7:0]      hlt_sig;
  logic [IW-1:0]   hlt_idx;
  logic [XLEN-1:0] hlt_adr;

  typedef struct {
    string           tag;
    logic            h;
    logic [7:0]      sig;
    logic [IW-1:0]   idx;
    logic [XLEN-1:0] adr;
  } exp_t;

  exp_t sb[$];
  int   n_cmp  = 0;
  int   n_fail = 0;

  nerv_dbg_trig #(.XLEN(XLEN), .BNUM(BNUM)) dut (
    .clk(clk), .rst(rst),
    .ret_vld(ret_vld), .ret_pc(ret_pc),
    .mem_vld(mem_vld), .mem_wr(mem_wr), .mem_adr(mem_adr),
    .cfg_we(cfg_we), .cfg_idx(cfg_idx), .cfg_ena(cfg_ena), .cfg_typ(cfg_typ), .cfg_adr(cfg_adr),
    .cmd_vld(cmd_vld), .cmd_op(cmd_op), .cmd_rdy(cmd_rdy),
    .cpu_stall(cpu_stall), .hlt(hlt),
    .hlt_sig(hlt_sig), .hlt_idx(hlt_idx), .hlt_adr(hlt_adr)
  );

  always #5 clk = ~clk;

  task automatic clr();
    ret_vld = 1'b0; mem_vld = 1'b0; mem_wr = 1'b0; cfg_we = 1'b0; cmd_vld = 1'b0;
  endtask

  // Push the expected status, clock the driven inputs in, then pop and compare.
  task automatic step(input string tag, input logic h, input logic [7:0] sig,
                      input logic [IW-1:0] idx, input logic [XLEN-1:0] adr);
    exp_t e;
    sb.push_back('{tag, h, sig, idx, adr});
    @(posedge clk);
    #1;
    clr();
    if (sb.size() == 0) begin
      n_cmp++;
      n_fail++;
      $error("FAIL %s scoreboard empty", tag);
    end else begin
      e = sb.pop_front();
      n_cmp++;
      assert (cpu_stall === e.h) else begin
        n_fail++; $error("FAIL %s.cpu_stall got %0h exp %0h", e.tag, cpu_stall, e.h);
      end
      n_cmp++;
      assert (hlt === e.h) else begin
        n_fail++; $error("FAIL %s.hlt got %0h exp %0h", e.tag, hlt, e.h);
      end
      n_cmp++;
      assert (cmd_rdy === 1'b1) else begin
        n_fail++; $error("FAIL %s.cmd_rdy got %0h exp 1", e.tag, cmd_rdy);
      end
      n_cmp++;
      assert (hlt_sig === e.sig) else begin
        n_fail++; $error("FAIL %s.hlt_sig got %0d exp %0d", e.tag, hlt_sig, e.sig);
      end
      n_cmp++;
      assert (hlt_idx === e.idx) else begin
        n_fail++; $error("FAIL %s.hlt_idx got %0d exp %0d", e.tag, hlt_idx, e.idx);
      end
      n_cmp++;
      assert (hlt_adr === e.adr) else begin
        n_fail++; $error("FAIL %s.hlt_adr got %h exp %h", e.tag, hlt_adr, e.adr);
      end
    end
  endtask

  task automatic drv_cmd(input logic [1:0] op);
    cmd_vld = 1'b1; cmd_op = op;
  endtask

  task automatic drv_ret(input logic [XLEN-1:0] pc);
    ret_vld = 1'b1; ret_pc = pc;
  endtask

  task automatic drv_cfg(input logic [IW-1:0] idx, input logic ena, input logic [1:0] typ,
                         input logic [XLEN-1:0] adr);
    cfg_we = 1'b1; cfg_idx = idx; cfg_ena = ena; cfg_typ = typ; cfg_adr = adr;
  endtask

  task automatic drv_mem(input logic wr, input logic [XLEN-1:0] adr);
    mem_vld = 1'b1; mem_wr = wr; mem_adr = adr;
  endtask

  initial begin
    logic [7:0]      ws;
    logic [IW-1:0]   wi;
    logic [XLEN-1:0] wa;
    clr();
    rst = 1'b0; ret_pc = '0; mem_adr = '0; cfg_idx = '0; cfg_ena = 1'b0;
    cfg_typ = 2'd0; cfg_adr = '0; cmd_op = 2'd0;

    // Reset and basic continue / halt
    step("rst0", 1, 8'd5, 2'd0, 32'h0);
    step("rst1", 1, 8'd5, 2'd0, 32'h0);
    rst = 1'b1;
    drv_ret(32'h100);  step("ret_halted", 1, 8'd5, 2'd0, 32'h0);
    drv_cmd(2'd0);     step("cont", 0, 8'd5, 2'd0, 32'h0);
    drv_ret(32'h104);  step("run_ret1", 0, 8'd5, 2'd0, 32'h0);
    drv_ret(32'h108);  step("run_ret2", 0, 8'd5, 2'd0, 32'h0);
    drv_cmd(2'd2);     step("halt_cmd", 1, 8'd2, 2'd0, 32'h108);
    drv_cmd(2'd2);     step("halt_in_halted", 1, 8'd2, 2'd0, 32'h108);

    // Exec breakpoint and resume from breakpoint PC
    drv_cfg(2'd0, 1'b1, 2'd0, 32'h10); step("cfg0", 1, 8'd2, 2'd0, 32'h108);
    drv_cmd(2'd0);     step("bp_cont", 0, 8'd2, 2'd0, 32'h108);
    drv_ret(32'h0C);   step("bp_ret0c", 0, 8'd2, 2'd0, 32'h108);
    drv_ret(32'h10);   step("bp_hit", 1, 8'd5, 2'd0, 32'h10);
    drv_cmd(2'd0);     step("bp_cont2", 0, 8'd5, 2'd0, 32'h10);
    drv_ret(32'h10);   step("bp_skip_first", 0, 8'd5, 2'd0, 32'h10);
    drv_cmd(2'd2);     step("bp_halt", 1, 8'd2, 2'd0, 32'h10);

    // Single step
    drv_cmd(2'd1);     step("step_cmd", 0, 8'd2, 2'd0, 32'h10);
    drv_ret(32'h20);   step("step_ret", 1, 8'd5, 2'd0, 32'h20);
    drv_cmd(2'd1);     step("step_cmd2", 0, 8'd5, 2'd0, 32'h20);
    for (int k = 0; k < 10; k++) begin
      step("step_idle", 0, 8'd5, 2'd0, 32'h20);
    end
    drv_cmd(2'd0);     step("step_cont_ign", 0, 8'd5, 2'd0, 32'h20);
    drv_cmd(2'd2);     step("step_halt", 1, 8'd2, 2'd0, 32'h20);

    // Multiple slots, lowest index, hit beats halt command
    drv_cfg(2'd1, 1'b1, 2'd0, 32'h40); step("cfg1", 1, 8'd2, 2'd0, 32'h20);
    drv_cfg(2'd3, 1'b1, 2'd0, 32'h40); step("cfg3", 1, 8'd2, 2'd0, 32'h20);
    drv_cmd(2'd0);     step("multi_cont", 0, 8'd2, 2'd0, 32'h20);
    drv_ret(32'h3C);   step("multi_ret3c", 0, 8'd2, 2'd0, 32'h20);
    drv_ret(32'h40); drv_cmd(2'd2);
    step("multi_hit_vs_halt", 1, 8'd5, 2'd1, 32'h40);
    drv_cfg(2'd1, 1'b0, 2'd0, 32'h40); step("cfg1_off", 1, 8'd5, 2'd1, 32'h40);
    drv_cmd(2'd0);     step("multi_cont2", 0, 8'd5, 2'd1, 32'h40);
    drv_ret(32'h30);   step("multi_ret30", 0, 8'd5, 2'd1, 32'h40);
    drv_ret(32'h40);   step("multi_hit3", 1, 8'd5, 2'd3, 32'h40);

    // Data watchpoint, slot configured while running
    drv_cmd(2'd0);     step("w_cont", 0, 8'd5, 2'd3, 32'h40);
    drv_cfg(2'd2, 1'b1, 2'd1, 32'h8000_0000); step("w_cfg_run", 0, 8'd5, 2'd3, 32'h40);
    drv_ret(32'h50);   step("w_ret50", 0, 8'd5, 2'd3, 32'h40);
    drv_mem(1'b0, 32'h8000_0000); step("w_read", 0, 8'd5, 2'd3, 32'h40);
    ws = WATCH ? 8'd5 : 8'd5;
    wi = WATCH ? 2'd2 : 2'd3;
    wa = WATCH ? 32'h8000_0000 : 32'h40;
    drv_mem(1'b1, 32'h8000_0000); step("w_write", WATCH, ws, wi, wa);
    ws = WATCH ? 8'd5 : 8'd2;
    wa = WATCH ? 32'h8000_0000 : 32'h50;
    drv_cmd(2'd2);     step("w_halt", 1, ws, wi, wa);

    // Reset during RUN overrides command, hit and config write
    drv_cmd(2'd0);     step("r_cont", 0, ws, wi, wa);
    rst = 1'b0;
    drv_cmd(2'd2); drv_ret(32'h40); drv_cfg(2'd0, 1'b1, 2'd0, 32'h60);
    step("r_reset", 1, 8'd5, 2'd0, 32'h0);
    rst = 1'b1;
    drv_cmd(2'd0);     step("r_cont2", 0, 8'd5, 2'd0, 32'h0);
    drv_cmd(2'd2);     step("r_halt_lastpc0", 1, 8'd2, 2'd0, 32'h0);
    drv_cmd(2'd0);     step("r_cont3", 0, 8'd2, 2'd0, 32'h0);
    drv_ret(32'h10);   step("r_ret10", 0, 8'd2, 2'd0, 32'h0);
    drv_ret(32'h40);   step("r_ret40", 0, 8'd2, 2'd0, 32'h0);
    drv_ret(32'h60);   step("r_ret60", 0, 8'd2, 2'd0, 32'h0);
    drv_mem(1'b1, 32'h8000_0000); step("r_memwr", 0, 8'd2, 2'd0, 32'h0);
    drv_cmd(2'd2);     step("r_halt", 1, 8'd2, 2'd0, 32'h60);

    if (sb.size() != 0) begin
      n_cmp++;
      n_fail++;
      $error("FAIL scoreboard_leftover got %0d exp 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
